sbox_scheduler: RTL
===================

SBOX_SCHEDULER -- requirements
Module: sbox_scheduler

Interface
REQ-001 SHALL have parameter KEY_PRIORITY, default 1; selects the requester granted first after reset when both request (1 = key schedule, 0 = state).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port st_req  input  1  state requester wants a 16-byte SubBytes job; level, held until st_ack.
REQ-005 SHALL have port st_data  input  128  state to substitute; byte i = st_data[127-8i -: 8].
REQ-006 SHALL have port st_ack  output  1  combinational; high in the cycle st_data is sampled.
REQ-007 SHALL have port st_result  output  128  substituted state, same byte order.
REQ-008 SHALL have port st_done  output  1  registered one-cycle pulse; st_result complete.
REQ-009 SHALL have port ks_req  input  1  key-schedule requester wants a 4-byte SubWord job; level, held until ks_ack.
REQ-010 SHALL have port ks_word  input  32  word to substitute; byte i = ks_word[31-8i -: 8].
REQ-011 SHALL have port ks_ack  output  1  combinational; high in the cycle ks_word is sampled.
REQ-012 SHALL have port ks_result  output  32  substituted word.
REQ-013 SHALL have port ks_done  output  1  registered one-cycle pulse; ks_result complete.
REQ-014 SHALL have port sbox_addr  output  8  byte presented to the single shared combinational sbox.
REQ-015 SHALL have port sbox_result  input  8  sbox output for sbox_addr, valid same cycle.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ST_RUN, KS_RUN with a 4-bit byte counter cnt.
REQ-018 In IDLE with exactly one request high, SHALL assert that requester's ack, capture its data at the edge, clear cnt, and enter ST_RUN or KS_RUN.
REQ-019 In IDLE with both requests high, SHALL grant the requester not served last; if none served since reset, SHALL grant per KEY_PRIORITY.
REQ-020 Acks SHALL be low outside IDLE; requests arriving while busy wait, never dropped or reordered.
REQ-021 In ST_RUN/KS_RUN, sbox_addr SHALL equal captured byte cnt; at each edge sbox_result SHALL be written to result byte cnt and cnt incremented.
REQ-022 ST_RUN SHALL last exactly 16 cycles (cnt 0..15), KS_RUN exactly 4 (cnt 0..3); at the final edge the FSM SHALL return to IDLE.
REQ-023 st_done/ks_done SHALL be high for exactly the cycle after the final write: 17 / 5 cycles after the acceptance edge.
REQ-024 A new job SHALL be acceptable in the done cycle (back-to-back, no idle gap).
REQ-025 st_result/ks_result SHALL be written only by their own job and hold value between jobs; a partially written result is not valid until done.
REQ-026 In IDLE, sbox_addr SHALL be 8'h00.
REQ-027 Requester data inputs SHALL be ignored after the acceptance edge.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, cnt=0, st_result=0, ks_result=0, st_done=0, ks_done=0, busy=0, and clear last-served history.
REQ-029 Reset mid-job SHALL abandon the job with no done pulse; the requester must re-request.

Verification
REQ-030 st_data=00112233445566778899aabbccddeeff -> st_ack one cycle; st_result=638293c31bfc33f5c4eeacea4bc12816; st_done 17 cycles after acceptance edge; busy high 16 cycles.
REQ-031 ks_word=09cf4f3c -> ks_result=018a84eb; ks_done 5 cycles after acceptance edge; st_result unchanged.
REQ-032 After reset, st_req and ks_req rise together, KEY_PRIORITY=1 -> key job first; state job accepted in the ks_done cycle; st_done 22 cycles after first acceptance.
REQ-033 Both requests held continuously over 4 jobs -> grants alternate KS, ST, KS, ST; no idle cycles between jobs.
REQ-034 Reset asserted in ST_RUN at cnt=7 -> all outputs 0 same cycle, no st_done; subsequent job returns correct result.
REQ-035 Two state jobs back-to-back (second st_req held) -> second accepted in first st_done cycle; both results correct.

Source files
------------

// File: rtl/sbox_scheduler.sv
// -----------------------------------------------------------------------------
// sbox_scheduler
//
// Time-multiplexes one shared combinational AES S-box between two requesters:
// the cipher state path (16-byte SubBytes jobs) and the key schedule
// (4-byte SubWord jobs). One byte is substituted per clock. Between jobs the
// arbiter alternates when both sides wait; the first contended grant after
// reset goes to the side chosen by KEY_PRIORITY.
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous, active-high reset
//   st_req       : state job request (level, held until st_ack)
//   st_data      : 128-bit state, byte i = st_data[127-8i -: 8]
//   st_ack       : combinational, high in the cycle st_data is captured
//   st_result    : substituted state, same byte order
//   st_done      : one-cycle pulse, st_result complete
//   ks_req       : key-schedule job request (level, held until ks_ack)
//   ks_word      : 32-bit word, byte i = ks_word[31-8i -: 8]
//   ks_ack       : combinational, high in the cycle ks_word is captured
//   ks_result    : substituted word
//   ks_done      : one-cycle pulse, ks_result complete
//   sbox_addr    : byte presented to the shared S-box (0 when idle)
//   sbox_result  : S-box output for sbox_addr, same cycle
//   busy         : high while a job is running
// -----------------------------------------------------------------------------
module sbox_scheduler #(
    parameter int KEY_PRIORITY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_req,
    input  logic [127:0] st_data,
    output logic         st_ack,
    output logic [127:0] st_result,
    output logic         st_done,
    input  logic         ks_req,
    input  logic [31:0]  ks_word,
    output logic         ks_ack,
    output logic [31:0]  ks_result,
    output logic         ks_done,
    output logic [7:0]   sbox_addr,
    input  logic [7:0]   sbox_result,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KS_RUN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;

    // Captured job bytes. A key-schedule word is parked in the top 32 bits so
    // both job types read their byte cnt from the same place.
    logic [127:0]   cap_q;
    logic [7:0]     cap_bytes [16];

    logic [127:0]   st_result_q, st_result_d;
    logic [31:0]    ks_result_q, ks_result_d;
    logic           st_done_q;
    logic           ks_done_q;

    // Arbitration history: has anything been granted since reset, and was the
    // most recent grant the key schedule.
    logic           served_any_q;
    logic           last_ks_q;

    logic           prefer_ks;
    logic           grant_st;
    logic           grant_ks;
    logic           accept;

    // ------------------------------------------------------------------
    // Arbitration (meaningful only in IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        prefer_ks = served_any_q ? !last_ks_q : (KEY_PRIORITY != 0);
        grant_ks  = ks_req && (!st_req || prefer_ks);
        grant_st  = st_req && (!ks_req || !prefer_ks);
        accept    = (state_q == IDLE) && (grant_st || grant_ks);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (grant_ks) begin
                    state_d = KS_RUN;
                end else if (grant_st) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            KS_RUN: begin
                if (cnt_q == 4'd3) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Acks are masked by reset so every output reads zero while reset is held,
    // even if a requester keeps its request raised.
    always_comb begin
        busy      = (state_q != IDLE);
        st_ack    = (state_q == IDLE) && grant_st && !reset;
        ks_ack    = (state_q == IDLE) && grant_ks && !reset;
        sbox_addr = busy ? cap_bytes[cnt_q] : 8'h00;
    end

    // ------------------------------------------------------------------
    // Byte views of the capture register
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cap_bytes
            assign cap_bytes[gi] = cap_q[127-8*gi -: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result byte write enables: each result byte changes only in the cycle
    // its own job presents that byte index; all other bytes hold.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_st_bytes
            assign st_result_d[127-8*gi -: 8] =
                (state_q == ST_RUN && cnt_q == 4'(gi)) ? sbox_result
                                                       : st_result_q[127-8*gi -: 8];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_ks_bytes
            assign ks_result_d[31-8*gi -: 8] =
                (state_q == KS_RUN && cnt_q == 4'(gi)) ? sbox_result
                                                       : ks_result_q[31-8*gi -: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q        <= 128'd0;
            st_result_q  <= 128'd0;
            ks_result_q  <= 32'd0;
            st_done_q    <= 1'b0;
            ks_done_q    <= 1'b0;
            served_any_q <= 1'b0;
            last_ks_q    <= 1'b0;
        end else begin
            st_result_q <= st_result_d;
            ks_result_q <= ks_result_d;
            // Done fires in the cycle after the final byte write.
            st_done_q   <= (state_q == ST_RUN) && (cnt_q == 4'd15);
            ks_done_q   <= (state_q == KS_RUN) && (cnt_q == 4'd3);
            if (accept) begin
                cap_q        <= grant_ks ? {ks_word, 96'd0} : st_data;
                served_any_q <= 1'b1;
                last_ks_q    <= grant_ks;
            end
        end
    end

    assign st_result = st_result_q;
    assign ks_result = ks_result_q;
    assign st_done   = st_done_q;
    assign ks_done   = ks_done_q;

endmodule
